// File: rtl/time_pkg.sv
`default_nettype none
// ============================================================================
// Package : time_pkg
// Summary : Shared widths, FSM/digit encodings and seven-segment patterns.
// Revision: 1.0 - initial release
// ============================================================================
package time_pkg;

    localparam int TIME_W = 6;
    localparam int BCD_W  = 4;

    typedef logic [TIME_W-1:0] time_val_t;
    typedef logic [BCD_W-1:0]  bcd_nibble_t;

    // Field order matches the {hour BCD, minute BCD} accumulator concatenation.
    typedef struct packed {
        bcd_nibble_t hr_tens;
        bcd_nibble_t hr_ones;
        bcd_nibble_t min_tens;
        bcd_nibble_t min_ones;
    } digits_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [2:0] SHIFT_LAST = 3'(TIME_W - 1);

    localparam logic [1:0] DIG_MIN_ONES = 2'd0;
    localparam logic [1:0] DIG_MIN_TENS = 2'd1;
    localparam logic [1:0] DIG_HR_ONES  = 2'd2;
    localparam logic [1:0] DIG_HR_TENS  = 2'd3;

    // Active-low {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Double-dabble correction applied to each nibble before the shift.
    function automatic bcd_nibble_t dd_adjust(input bcd_nibble_t n);
        return (n >= 4'd5) ? bcd_nibble_t'(n + 4'd3) : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module  : seg7_decode
// Summary : Combinational BCD nibble to active-low seven-segment pattern.
// Revision: 1.0 - initial release
// ============================================================================
module seg7_decode
    import time_pkg::*;
(
    input  logic [BCD_W-1:0] i_nibble,
    output logic [6:0]       o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nibble)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/time_display.sv
`default_nettype none
// ============================================================================
// Module  : time_display
// Summary : Snapshots hour/minute counts, converts them to BCD with a
//           sequential double-dabble and scans a four-digit HH:MM display.
// Revision: 1.0 - initial release
// ============================================================================
module time_display
    import time_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TIME_W-1:0] hr_counter,
    input  logic [TIME_W-1:0] min_counter,
    input  logic              hour,
    output logic [6:0]        seg,
    output logic [3:0]        an,
    output logic              dp,
    output logic              busy
);

    localparam int               CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] c_ref_max = CNT_W'(REFRESH_DIV - 1);

    logic [1:0]             r_state;
    logic [2:0]             r_step;
    time_val_t              r_snap_hr;
    time_val_t              r_snap_min;
    time_val_t              r_sh_hr;
    time_val_t              r_sh_min;
    logic [2*BCD_W-1:0]     r_bcd_hr;
    logic [2*BCD_W-1:0]     r_bcd_min;
    digits_t                r_disp;
    logic                   r_busy;

    logic [CNT_W-1:0]       r_ref_cnt;
    logic [1:0]             r_idx;
    logic                   r_colon;

    logic [6:0]             r_seg;
    logic [3:0]             r_an;
    logic                   r_dp;

    logic [2*BCD_W-1:0]     w_hr_adj;
    logic [2*BCD_W-1:0]     w_min_adj;
    logic                   w_changed;
    bcd_nibble_t            w_nibble;
    logic [6:0]             w_dec_seg;
    logic                   w_blank;
    logic [6:0]             w_seg_next;
    logic [3:0]             w_an_next;
    logic                   w_dp_next;

    assign w_hr_adj  = {dd_adjust(r_bcd_hr[7:4]),  dd_adjust(r_bcd_hr[3:0])};
    assign w_min_adj = {dd_adjust(r_bcd_min[7:4]), dd_adjust(r_bcd_min[3:0])};
    assign w_changed = ({hr_counter, min_counter} != {r_snap_hr, r_snap_min});

    // Conversion FSM: display registers only change in COMMIT, so HH:MM is never torn.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_step     <= 3'd0;
            r_snap_hr  <= '0;
            r_snap_min <= '0;
            r_sh_hr    <= '0;
            r_sh_min   <= '0;
            r_bcd_hr   <= '0;
            r_bcd_min  <= '0;
            r_disp     <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_changed) begin
                        r_snap_hr  <= hr_counter;
                        r_snap_min <= min_counter;
                        r_sh_hr    <= hr_counter;
                        r_sh_min   <= min_counter;
                        r_bcd_hr   <= '0;
                        r_bcd_min  <= '0;
                        r_step     <= 3'd0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Truncating cast drops the adjusted MSB, which is always 0 for inputs <= 63.
                    r_bcd_hr  <= (2*BCD_W)'({w_hr_adj,  r_sh_hr[TIME_W-1]});
                    r_bcd_min <= (2*BCD_W)'({w_min_adj, r_sh_min[TIME_W-1]});
                    r_sh_hr   <= {r_sh_hr[TIME_W-2:0],  1'b0};
                    r_sh_min  <= {r_sh_min[TIME_W-2:0], 1'b0};
                    r_step    <= r_step + 3'd1;
                    if (r_step == SHIFT_LAST) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    r_disp  <= {r_bcd_hr, r_bcd_min};
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_cnt <= '0;
            r_idx     <= DIG_MIN_ONES;
        end else if (r_ref_cnt == c_ref_max) begin
            r_ref_cnt <= '0;
            r_idx     <= r_idx + 2'd1;
        end else begin
            r_ref_cnt <= r_ref_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_colon <= 1'b0;
        end else if (hour) begin
            r_colon <= ~r_colon;
        end
    end

    always_comb begin
        w_nibble  = r_disp.min_ones;
        w_an_next = 4'b1110;
        case (r_idx)
            DIG_MIN_ONES: begin w_nibble = r_disp.min_ones; w_an_next = 4'b1110; end
            DIG_MIN_TENS: begin w_nibble = r_disp.min_tens; w_an_next = 4'b1101; end
            DIG_HR_ONES:  begin w_nibble = r_disp.hr_ones;  w_an_next = 4'b1011; end
            DIG_HR_TENS:  begin w_nibble = r_disp.hr_tens;  w_an_next = 4'b0111; end
            default:      begin w_nibble = r_disp.min_ones; w_an_next = 4'b1110; end
        endcase
    end

    seg7_decode u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_dec_seg)
    );

    assign w_blank    = BLANK_LZ && (r_idx == DIG_HR_TENS) && (r_disp.hr_tens == 4'd0);
    assign w_seg_next = w_blank ? SEG_BLANK : w_dec_seg;
    assign w_dp_next  = (r_idx == DIG_HR_ONES) ? ~r_colon : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= SEG_0;
            r_an  <= 4'b1110;
            r_dp  <= 1'b1;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
            r_dp  <= w_dp_next;
        end
    end

    assign seg  = r_seg;
    assign an   = r_an;
    assign dp   = r_dp;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_time_display.sv
`default_nettype none
// ============================================================================
// Module  : tb_time_display
// Summary : Self-checking bench for time_display (plain and blanking builds).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_time_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] hr;
    logic [5:0] mn;
    logic       hour;
    logic [6:0] seg0, seg1;
    logic [3:0] an0, an1;
    logic       dp0, dp1, busy0, busy1;

    time_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst(rst), .hr_counter(hr), .min_counter(mn), .hour(hour),
        .seg(seg0), .an(an0), .dp(dp0), .busy(busy0)
    );

    time_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut1 (
        .clk(clk), .rst(rst), .hr_counter(hr), .min_counter(mn), .hour(hour),
        .seg(seg1), .an(an1), .dp(dp1), .busy(busy1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] pat [10];

    // Reference model: time in edges since reset, digits via / and %.
    int   m_n, m_colon, m_cyc, m_free_at, m_commit_at, m_snap_hr, m_snap_min;
    int   m_disp [4];
    logic m_busy;
    logic [6:0] e_seg0, e_seg1;
    logic [3:0] e_an;
    logic       e_dp;

    logic [6:0] cap0 [4];
    logic [6:0] cap1 [4];

    typedef struct {
        logic [5:0] hr;
        logic [5:0] mn;
        logic [6:0] s_ht;
        logic [6:0] s_ho;
        logic [6:0] s_mt;
        logic [6:0] s_mo;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int idx;
        if (rst) begin
            m_n = 0; m_colon = 0; m_cyc = 0; m_free_at = 0; m_commit_at = -1;
            m_snap_hr = 0; m_snap_min = 0; m_busy = 1'b0;
            for (int i = 0; i < 4; i++) m_disp[i] = 0;
            e_seg0 = pat[0]; e_seg1 = pat[0]; e_an = 4'b1110; e_dp = 1'b1;
        end else begin
            idx = (m_n / DIV) % 4;
            case (idx)
                0:       e_an = 4'b1110;
                1:       e_an = 4'b1101;
                2:       e_an = 4'b1011;
                default: e_an = 4'b0111;
            endcase
            e_seg0 = pat[m_disp[idx]];
            e_seg1 = (idx == 3 && m_disp[3] == 0) ? 7'b1111111 : pat[m_disp[idx]];
            e_dp   = (idx == 2) ? (m_colon == 0) : 1'b1;
            if (m_cyc == m_commit_at) begin
                m_disp[3] = m_snap_hr / 10;  m_disp[2] = m_snap_hr % 10;
                m_disp[1] = m_snap_min / 10; m_disp[0] = m_snap_min % 10;
                m_busy = 1'b0;
            end
            if (m_cyc >= m_free_at && (int'(hr) != m_snap_hr || int'(mn) != m_snap_min)) begin
                m_snap_hr = int'(hr); m_snap_min = int'(mn);
                m_busy = 1'b1;
                m_commit_at = m_cyc + 7;
                m_free_at   = m_cyc + 8;
            end
            if (hour) m_colon = 1 - m_colon;
            m_n++;
            m_cyc++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("seg",       32'(seg0),  32'(e_seg0));
        chk("seg_blank", 32'(seg1),  32'(e_seg1));
        chk("an",        32'(an0),   32'(e_an));
        chk("an_blank",  32'(an1),   32'(e_an));
        chk("dp",        32'(dp0),   32'(e_dp));
        chk("dp_blank",  32'(dp1),   32'(e_dp));
        chk("busy",      32'(busy0), 32'(m_busy));
        chk("busy_blank",32'(busy1), 32'(m_busy));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic int an_idx(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            default: return 3;
        endcase
    endfunction

    task automatic scan();
        for (int i = 0; i < 4 * DIV; i++) begin
            tick();
            cap0[an_idx(an0)] = seg0;
            cap1[an_idx(an1)] = seg1;
        end
    endtask

    initial begin
        bit saw_low, bad;

        pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
        pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
        pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
        pat[9] = 7'b0010000;

        vecs[0] = '{6'd23, 6'd45, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010};
        vecs[1] = '{6'd63, 6'd59, 7'b0000010, 7'b0110000, 7'b0010010, 7'b0010000};
        vecs[2] = '{6'd0,  6'd0,  7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
        vecs[3] = '{6'd9,  6'd10, 7'b1000000, 7'b0010000, 7'b1111001, 7'b1000000};
        vecs[4] = '{6'd12, 6'd7,  7'b1111001, 7'b0100100, 7'b1000000, 7'b1111000};

        rst = 1'b1; hr = '0; mn = '0; hour = 1'b0;
        ticks(2);
        rst = 1'b0;
        ticks(8 * DIV);

        for (int v = 0; v < 5; v++) begin
            hr = vecs[v].hr; mn = vecs[v].mn;
            ticks(9);
            scan();
            chk("vec_hr_tens",  32'(cap0[3]), 32'(vecs[v].s_ht));
            chk("vec_hr_ones",  32'(cap0[2]), 32'(vecs[v].s_ho));
            chk("vec_min_tens", 32'(cap0[1]), 32'(vecs[v].s_mt));
            chk("vec_min_ones", 32'(cap0[0]), 32'(vecs[v].s_mo));
        end

        // Input change two edges into a conversion is picked up by the next one.
        hr = 6'd12; mn = 6'd10;
        tick();
        chk("busy_at_capture", 32'(busy0), 32'd1);
        tick();
        mn = 6'd11;
        ticks(5);
        chk("busy_before_commit", 32'(busy0), 32'd1);
        tick();
        chk("busy_after_commit", 32'(busy0), 32'd0);
        tick();
        chk("busy_restart", 32'(busy0), 32'd1);
        ticks(8);
        scan();
        chk("restart_min_tens", 32'(cap0[1]), 32'(pat[1]));
        chk("restart_min_ones", 32'(cap0[0]), 32'(pat[1]));

        // Colon toggling from a clean reset.
        rst = 1'b1; tick(); rst = 1'b0;
        hour = 1'b1; tick(); hour = 1'b0;
        saw_low = 1'b0; bad = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (dp0 == 1'b0) begin
                if (an0 == 4'b1011) saw_low = 1'b1; else bad = 1'b1;
            end
        end
        chk("colon_on_seen",   32'(saw_low), 32'd1);
        chk("colon_only_hr1",  32'(bad),     32'd0);
        hour = 1'b1; hr = hr + 6'd1;
        tick();
        hour = 1'b0;
        saw_low = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (dp0 == 1'b0) saw_low = 1'b1;
        end
        chk("colon_off", 32'(saw_low), 32'd0);

        // Leading-zero blanking only on the BLANK_LZ instance.
        hr = 6'd5; mn = 6'd0;
        ticks(9);
        scan();
        chk("blank_hr5",   32'(cap1[3]), 32'h7F);
        chk("noblank_hr5", 32'(cap0[3]), 32'(pat[0]));
        chk("blank_hr5_ones", 32'(cap1[2]), 32'(pat[5]));
        hr = 6'd15;
        ticks(9);
        scan();
        chk("blank_hr15", 32'(cap1[3]), 32'(pat[1]));

        // Reset in the middle of SHIFT discards the partial result.
        hr = 6'd7; mn = 6'd8;
        ticks(9);
        hr = 6'd9; mn = 6'd9;
        ticks(3);
        rst = 1'b1; hr = '0; mn = '0;
        tick();
        chk("rst_mid_busy", 32'(busy0), 32'd0);
        rst = 1'b0;
        ticks(9);
        scan();
        for (int i = 0; i < 4; i++) chk("rst_mid_digit", 32'(cap0[i]), 32'(pat[0]));

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) hr = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 19) == 0) mn = 6'($urandom_range(0, 63));
            hour = ($urandom_range(0, 49) == 0);
            rst  = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0; hour = 1'b0;
        ticks(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/time_display.md
Name: time_display

Overview:
Downstream consumer of the hour/minute counter stage. Snapshots the binary hour and minute counts and converts them to BCD with a sequential double-dabble FSM. Time-multiplexes four common-anode seven-segment digits (HH:MM) with a configurable refresh divider. Uses the `hour` rollover pulse to toggle the colon decimal point.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit stays enabled (>=2)
BLANK_LZ, 0, 1 = blank hour-tens digit when it is 0

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
hr_counter  input  6  binary hour-stage count (0..63 accepted)
min_counter  input  6  binary minute-stage count (0..63 accepted)
hour  input  1  single-cycle rollover pulse from upstream
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
an  output  4  digit enables, one-hot active-low; an[3] = leftmost
dp  output  1  decimal point, active-low
busy  output  1  high while a conversion is in flight

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - FSM = IDLE; snapshot regs = 0; displayed digits = 0,0,0,0
  - refresh counter = 0; digit index = 0; colon state = 0; busy = 0
  - an = 4'b1110; seg = 7'b1000000 ("0"); dp = 1 (off)
- FSM states IDLE, SHIFT, COMMIT:
  - IDLE: each cycle compare {hr_counter, min_counter} with the snapshot.
    - If different: capture both into the snapshot and the shift regs, clear the BCD accumulators, go to SHIFT, busy = 1.
    - If equal: stay in IDLE.
  - SHIFT: exactly 6 cycles, via a 3-bit step count 0..5.
    - Each cycle, first add 3 to any BCD nibble >= 5, then shift left 1.
    - Hour and minute are converted in parallel, 6-bit in -> 8-bit BCD out (max 63).
  - COMMIT: 1 cycle.
    - Load the four displayed-digit regs from the accumulators.
    - busy = 0; go to IDLE.
- Latency: input change present before edge E -> captured at E, SHIFT at E+1..E+6, displayed digits updated at E+7.
- Inputs changing during SHIFT/COMMIT are ignored.
  - The next IDLE cycle re-compares and starts a new conversion if needed.
  - No change is lost; intermediate values may be skipped.
- Displayed digits never update mid-conversion, so no torn HH:MM.
- Refresh:
  - Counter runs 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - On wrap, digit index advances 0->1->2->3->0.
  - Digit map:
    - index 0: min ones, an = 1110
    - index 1: min tens, an = 1101
    - index 2: hr ones, an = 1011
    - index 3: hr tens, an = 0111
- seg/an/dp are registered: they reflect the new index one cycle after the wrap edge.
- Decode:
  - 0..9 to standard active-low patterns.
  - Any other nibble to all-off (7'b1111111), a defensive case only.
- Blanking: if BLANK_LZ = 1, index 3 and hr tens = 0 -> seg = 7'b1111111 (an still asserted).
- Colon:
  - `hour` = 1 toggles the colon state the same edge.
  - dp = ~colon when index = 2, else 1.
  - Simultaneous `hour` and an input change: both handled independently.
- rst mid-conversion: returns to reset values immediately and discards the partial result.
  - The next IDLE cycle re-converts the live inputs unless they equal 0,0.

Decomposition:
- Shared package (time_pkg):
  - seven-segment pattern constants SEG_0..SEG_9, SEG_BLANK
  - digit-index encoding, FSM state encoding
  - counter widths (6-bit time value, 4-bit BCD nibble)
- Sub-module seg7_decode: combinational nibble -> active-low pattern. Reused by any later display block.
- The double-dabble FSM stays inline.

Test Plan:
- Reset, REFRESH_DIV=4 -> an cycles 1110,1101,1011,0111 every 4 clocks; seg = 7'b1000000 on every digit; dp = 1; busy = 0.
- hr=23, min=45 applied before edge E -> busy high E..E+6; digits 2,3,4,5 loaded at E+7; scan shows seg 0100100 (2), 0110000 (3), 0011001 (4), 0010010 (5) on an 0111, 1011, 1101, 1110.
- hr=63, min=59 -> BCD 6,3,5,9 after 7 cycles; verifies add-3 correction on both nibbles.
- Change min 10->11 at E+2 of a conversion -> first commit shows 10; second conversion starts the cycle after COMMIT; 11 is displayed 8 cycles later; no intermediate garbage digits.
- Two `hour` pulses 1000 cycles apart -> dp low only while an = 1011 after the first pulse, permanently high after the second; pulse coincident with an input change still toggles.
- BLANK_LZ=1, hr=5 -> an = 0111 shows seg 1111111; hr=15 -> shows "1". Assert rst mid-SHIFT -> next cycle busy = 0, digits "0000".
